// File: rtl/lm32_wb_bus_arbiter_if.sv
// Wishbone signal bundle between the two LM32 masters, the arbiter and the shared slave port.
// "slave" is the arbiter's view; "master" is the view of the surrounding CPU/interconnect.
interface lm32_wb_bus_arbiter_if;
    logic [1:0]  M_CYC_I;
    logic [1:0]  M_STB_I;
    logic [1:0]  M_WE_I;
    logic [1:0]  M_LOCK_I;
    logic [63:0] M_ADR_I;
    logic [63:0] M_DAT_I;
    logic [7:0]  M_SEL_I;
    logic [5:0]  M_CTI_I;
    logic [3:0]  M_BTE_I;
    logic [31:0] M_DAT_O;
    logic [1:0]  M_ACK_O;
    logic [1:0]  M_ERR_O;
    logic [1:0]  M_RTY_O;
    logic        S_CYC_O;
    logic        S_STB_O;
    logic        S_WE_O;
    logic [31:0] S_ADR_O;
    logic [31:0] S_DAT_O;
    logic [3:0]  S_SEL_O;
    logic [2:0]  S_CTI_O;
    logic [1:0]  S_BTE_O;
    logic [31:0] S_DAT_I;
    logic        S_ACK_I;
    logic        S_ERR_I;
    logic        S_RTY_I;

    modport slave (
        input  M_CYC_I, M_STB_I, M_WE_I, M_LOCK_I, M_ADR_I, M_DAT_I, M_SEL_I, M_CTI_I, M_BTE_I,
        input  S_DAT_I, S_ACK_I, S_ERR_I, S_RTY_I,
        output M_DAT_O, M_ACK_O, M_ERR_O, M_RTY_O,
        output S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O, S_SEL_O, S_CTI_O, S_BTE_O
    );

    modport master (
        output M_CYC_I, M_STB_I, M_WE_I, M_LOCK_I, M_ADR_I, M_DAT_I, M_SEL_I, M_CTI_I, M_BTE_I,
        output S_DAT_I, S_ACK_I, S_ERR_I, S_RTY_I,
        input  M_DAT_O, M_ACK_O, M_ERR_O, M_RTY_O,
        input  S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O, S_SEL_O, S_CTI_O, S_BTE_O
    );
endinterface

// File: rtl/lm32_wb_bus_arbiter.sv
// Two-master (instruction=0, data=1) to one-slave Wishbone arbiter with lock and a slave watchdog.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise the data master wins ties.
module lm32_wb_bus_arbiter #(
    parameter int unsigned WB_TIMEOUT = 256
) (
    input logic                  clk_i,
    input logic                  rst_i,
    lm32_wb_bus_arbiter_if.slave bus
);
    localparam int unsigned CW = (WB_TIMEOUT > 0) ? $clog2(WB_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = (WB_TIMEOUT > 0) ? CW'(WB_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        state, state_next;
    logic          last_grant;
    logic [CW-1:0] wd_cnt;
    logic          sel, gnt, resp_any, wd_fire, tie_pick;

`ifdef WB_ARB_ROUND_ROBIN_EN
    assign tie_pick = ~last_grant;
`else
    // last_grant is maintained in both builds; fixed priority ignores it.
    assign tie_pick = 1'b1 | last_grant;
`endif

    assign resp_any = bus.S_ACK_I | bus.S_ERR_I | bus.S_RTY_I;

    always_comb begin
        sel          = (state == GNT1);
        gnt          = (state != IDLE);
        bus.M_DAT_O  = bus.S_DAT_I;
        bus.S_CYC_O  = gnt & bus.M_CYC_I[sel];
        bus.S_STB_O  = gnt & bus.M_CYC_I[sel] & bus.M_STB_I[sel];
        bus.S_WE_O   = 1'b0;
        bus.S_ADR_O  = '0;
        bus.S_DAT_O  = '0;
        bus.S_SEL_O  = '0;
        bus.S_CTI_O  = '0;
        bus.S_BTE_O  = '0;
        if (gnt) begin
            bus.S_WE_O  = bus.M_WE_I[sel];
            bus.S_ADR_O = sel ? bus.M_ADR_I[63:32] : bus.M_ADR_I[31:0];
            bus.S_DAT_O = sel ? bus.M_DAT_I[63:32] : bus.M_DAT_I[31:0];
            bus.S_SEL_O = sel ? bus.M_SEL_I[7:4]   : bus.M_SEL_I[3:0];
            bus.S_CTI_O = sel ? bus.M_CTI_I[5:3]   : bus.M_CTI_I[2:0];
            bus.S_BTE_O = sel ? bus.M_BTE_I[3:2]   : bus.M_BTE_I[1:0];
        end
        wd_fire = (WB_TIMEOUT != 0) && bus.S_STB_O && !resp_any && (wd_cnt == WD_LAST);
        bus.M_ACK_O      = '0;
        bus.M_ERR_O      = '0;
        bus.M_RTY_O      = '0;
        bus.M_ACK_O[sel] = bus.S_ACK_I & bus.S_STB_O;
        bus.M_ERR_O[sel] = (bus.S_ERR_I & bus.S_STB_O) | wd_fire;
        bus.M_RTY_O[sel] = bus.S_RTY_I & bus.S_STB_O;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (&bus.M_CYC_I)
                    state_next = tie_pick ? GNT1 : GNT0;
                else if (bus.M_CYC_I[0])
                    state_next = GNT0;
                else if (bus.M_CYC_I[1])
                    state_next = GNT1;
            end
            GNT0: begin
                if (wd_fire || (!bus.M_CYC_I[0] && !bus.M_LOCK_I[0]))
                    state_next = bus.M_CYC_I[1] ? GNT1 : IDLE;
            end
            GNT1: begin
                if (wd_fire || (!bus.M_CYC_I[1] && !bus.M_LOCK_I[1]))
                    state_next = bus.M_CYC_I[0] ? GNT0 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wd_cnt <= '0;
                if (state_next == GNT0)
                    last_grant <= 1'b0;
                else if (state_next == GNT1)
                    last_grant <= 1'b1;
            end else if (resp_any) begin
                wd_cnt <= '0;
            end else if (bus.S_STB_O) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_lm32_wb_bus_arbiter.sv
// Directed scoreboard bench for lm32_wb_bus_arbiter: stimulus pushes the expected per-cycle bus
// picture, a negedge monitor pops and compares it against the DUT.
module tb_lm32_wb_bus_arbiter;
    localparam int unsigned TMO = 8;
    localparam logic [31:0] ADR0 = 32'h1000_0000, ADR1 = 32'h2000_0004;
    localparam logic [31:0] WD0  = 32'hAAAA_0000, WD1  = 32'h5555_1111;
    localparam logic [3:0]  SEL0 = 4'hF,          SEL1 = 4'h3;
    localparam logic [1:0]  BTE0 = 2'b01,         BTE1 = 2'b10;
`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam int W = 0;
`else
    localparam int W = 1;
`endif
    localparam int L = 1 - W;
    localparam logic [1:0] GW = 2'(W + 1), GL = 2'(L + 1);
    localparam logic [1:0] BW = 2'(1 << W), BL = 2'(1 << L);

    typedef struct packed {
        logic        s_cyc, s_stb, s_we;
        logic [31:0] s_adr, s_dat;
        logic [3:0]  s_sel;
        logic [2:0]  s_cti;
        logic [1:0]  s_bte;
        logic [1:0]  m_ack, m_err, m_rty;
        logic [31:0] m_dat;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    obs_t sb[$];
    int   sb_id[$];
    int   step_no = 0;
    int   checks = 0;
    int   passes = 0;

    lm32_wb_bus_arbiter_if bus();

    lm32_wb_bus_arbiter #(.WB_TIMEOUT(TMO)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // g: expected grant (0 none, 1 instruction master, 2 data master)
    task automatic step(input logic r, input logic [1:0] cyc, input logic [1:0] stb,
                        input logic [1:0] lock, input logic [1:0] we,
                        input logic [2:0] cti0, input logic [2:0] cti1,
                        input logic ack, input logic err, input logic rty,
                        input logic [1:0] g, input logic [1:0] eack,
                        input logic [1:0] eerr, input logic [1:0] erty);
        obs_t e;
        logic [31:0] sd;
        @(posedge clk);
        #1;
        sd = $urandom;
        rst          = r;
        bus.M_CYC_I  = cyc;
        bus.M_STB_I  = stb;
        bus.M_LOCK_I = lock;
        bus.M_WE_I   = we;
        bus.M_CTI_I  = {cti1, cti0};
        bus.S_ACK_I  = ack;
        bus.S_ERR_I  = err;
        bus.S_RTY_I  = rty;
        bus.S_DAT_I  = sd;
        e = '0;
        if (g == 2'd1) begin
            e.s_cyc = cyc[0]; e.s_stb = cyc[0] & stb[0]; e.s_we = we[0];
            e.s_adr = ADR0; e.s_dat = WD0; e.s_sel = SEL0; e.s_cti = cti0; e.s_bte = BTE0;
        end else if (g == 2'd2) begin
            e.s_cyc = cyc[1]; e.s_stb = cyc[1] & stb[1]; e.s_we = we[1];
            e.s_adr = ADR1; e.s_dat = WD1; e.s_sel = SEL1; e.s_cti = cti1; e.s_bte = BTE1;
        end
        e.m_ack = eack;
        e.m_err = eerr;
        e.m_rty = erty;
        e.m_dat = sd;
        step_no++;
        sb.push_back(e);
        sb_id.push_back(step_no);
    endtask

    always @(negedge clk) begin
        obs_t e, o;
        int id;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            id = sb_id.pop_front();
            o  = {bus.S_CYC_O, bus.S_STB_O, bus.S_WE_O, bus.S_ADR_O, bus.S_DAT_O, bus.S_SEL_O,
                  bus.S_CTI_O, bus.S_BTE_O, bus.M_ACK_O, bus.M_ERR_O, bus.M_RTY_O, bus.M_DAT_O};
            checks++;
            if (o === e)
                passes++;
            else
                $display("FAIL bus_step%0d: got %h expected %h", id, o, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.M_CYC_I = '0; bus.M_STB_I = '0; bus.M_WE_I = '0; bus.M_LOCK_I = '0;
        bus.M_ADR_I = {ADR1, ADR0};
        bus.M_DAT_I = {WD1, WD0};
        bus.M_SEL_I = {SEL1, SEL0};
        bus.M_CTI_I = '0;
        bus.M_BTE_I = {BTE1, BTE0};
        bus.S_DAT_I = '0; bus.S_ACK_I = 1'b0; bus.S_ERR_I = 1'b0; bus.S_RTY_I = 1'b0;

        // reset: everything idle
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);

        // instruction master alone; ack on 2nd STB cycle, then a retry
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 1, 1, 2'b00, 2'b00, 2'b01);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 1, 1, 0, 2'b00, 2'b00, 2'b00);

        // tie with last_grant=0: both policies grant the data master first, handover without bubble
        step(0, 2'b11, 2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step(0, 2'b11, 2'b11, 2'b00, 2'b10, 3'b000, 3'b000, 1, 0, 0, 2, 2'b10, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 2, 2'b00, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);

        // data master alone with slave error, leaves last_grant=1
        step(0, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step(0, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1, 0, 2, 2'b00, 2'b10, 2'b00);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 2, 2'b00, 2'b00, 2'b00);

        // tie with last_grant=1: policy-dependent winner W, then loser L
        step(0, 2'b11, 2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0,  2'b00, 2'b00, 2'b00);
        step(0, 2'b11, 2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 0, GW, BW,    2'b00, 2'b00);
        step(0, BL,    BL,    2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, GW, 2'b00, 2'b00, 2'b00);
        step(0, BL,    BL,    2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 0, GL, BL,    2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, GL, 2'b00, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0,  2'b00, 2'b00, 2'b00);

        // data 4-beat incrementing burst while instruction master waits
        step(0, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000, 3'b010, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step(0, 2'b11, 2'b11, 2'b00, 2'b00, 3'b000, 3'b010, 1, 0, 0, 2, 2'b10, 2'b00, 2'b00);
        step(0, 2'b11, 2'b11, 2'b00, 2'b00, 3'b000, 3'b010, 1, 0, 0, 2, 2'b10, 2'b00, 2'b00);
        step(0, 2'b11, 2'b11, 2'b00, 2'b00, 3'b000, 3'b010, 1, 0, 0, 2, 2'b10, 2'b00, 2'b00);
        step(0, 2'b11, 2'b11, 2'b00, 2'b00, 3'b000, 3'b111, 1, 0, 0, 2, 2'b10, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 2, 2'b00, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);

        // watchdog: slave never answers, ERR on the 8th STB cycle, then IDLE
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 7; i++)
            step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);

        // data locked read, CYC gap, write; instruction master held off until unlock
        step(0, 2'b10, 2'b10, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step(0, 2'b11, 2'b11, 2'b10, 2'b00, 3'b000, 3'b000, 1, 0, 0, 2, 2'b10, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0, 0, 2, 2'b00, 2'b00, 2'b00);
        step(0, 2'b11, 2'b11, 2'b10, 2'b10, 3'b000, 3'b000, 1, 0, 0, 2, 2'b10, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 2, 2'b00, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b010, 3'b000, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        // reset mid-burst: ack still forwarded this cycle, suppressed after the sampling edge
        step(1, 2'b01, 2'b01, 2'b00, 2'b00, 3'b010, 3'b000, 1, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b010, 3'b000, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() == 0)
            passes++;
        else
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
